// File: rtl/obi_wb_pkg.sv
// Shared types and default constants for the OBI
// instruction/data to Wishbone-classic arbiter.
package obi_wb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } arb_state_e;

   typedef enum logic {
      PORT_INSTR,
      PORT_DATA
   } port_e;

   localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
   localparam logic [31:0] DEF_TIMEOUT_RDATA  = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: one-hot grant from
// two requests and the port that won last time.
module rr_arbiter2
   import obi_wb_pkg::*;
(
   input  logic [1:0] req,
   input  port_e      last_grant,
   output logic [1:0] gnt
);

   // On a tie the port that did not win last time goes first.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant == PORT_DATA) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/obi_wb_arbiter.sv
// Shares one Wishbone-classic master between the OBI
// instruction and data ports, one access at a time.
module obi_wb_arbiter
   import obi_wb_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA  = DEF_TIMEOUT_RDATA
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    instr_req_i,
   output logic                    instr_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
   output logic                    instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]   instr_rdata_o,
   input  logic                    data_req_i,
   output logic                    data_gnt_o,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic [ADDR_WIDTH-1:0]   wb_addr_o,
   output logic [DATA_WIDTH-1:0]   wb_data_o,
   input  logic [DATA_WIDTH-1:0]   wb_data_i,
   input  logic                    wb_ack_i,
   output logic                    bus_err_o
);

   localparam int unsigned SW = DATA_WIDTH / 8;
   localparam int unsigned CW =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

   arb_state_e state_q, state_d;
   port_e      last_q, owner_q, pick;
   logic [1:0] rr_gnt, gnt;
   logic       take, abort, tmo_hit;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [SW-1:0]         sel_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic [CW-1:0]         cnt_q;
   logic                  err_q;

   rr_arbiter2 u_rr (
      .req        ({data_req_i, instr_req_i}),
      .last_grant (last_q),
      .gnt        (rr_gnt)
   );

   assign pick    = rr_gnt[1] ? PORT_DATA : PORT_INSTR;
   assign tmo_hit = TMO_EN && (cnt_q == CNT_LAST);

   // Next state and the combinational grant, which only exists in IDLE.
   always_comb begin
      state_d = state_q;
      gnt     = 2'b00;
      take    = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         IDLE: begin
            gnt = rr_gnt & {2{rst_n}};
            if (|rr_gnt) begin
               state_d = BUS;
               take    = 1'b1;
            end
         end
         BUS: begin
            if (wb_ack_i) begin
               state_d = RESP;
            end else if (tmo_hit) begin
               state_d = RESP;
               abort   = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request capture, timeout counter and response data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q  <= PORT_DATA;
         owner_q <= PORT_INSTR;
         addr_q  <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (take) begin
            owner_q <= pick;
            last_q  <= pick;
            cnt_q   <= '0;
            if (pick == PORT_DATA) begin
               addr_q  <= data_addr_i;
               we_q    <= data_we_i;
               sel_q   <= data_be_i;
               wdata_q <= data_wdata_i;
            end else begin
               addr_q  <= instr_addr_i;
               we_q    <= 1'b0;
               sel_q   <= '1;
               wdata_q <= '0;
            end
         end
         if (state_q == BUS) begin
            if (cnt_q != CNT_MAX) begin
               cnt_q <= cnt_q + 1'b1;
            end
            if (wb_ack_i) begin
               rdata_q <= we_q ? '0 : wb_data_i;
            end else if (abort) begin
               rdata_q <= TIMEOUT_RDATA;
               err_q   <= 1'b1;
            end
         end
      end
   end

   assign instr_gnt_o = gnt[0];
   assign data_gnt_o  = gnt[1];

   assign instr_rvalid_o = (state_q == RESP) && (owner_q == PORT_INSTR);
   assign data_rvalid_o  = (state_q == RESP) && (owner_q == PORT_DATA);
   assign instr_rdata_o  = instr_rvalid_o ? rdata_q : '0;
   assign data_rdata_o   = data_rvalid_o ? rdata_q : '0;

   assign wb_cyc_o  = (state_q == BUS);
   assign wb_stb_o  = (state_q == BUS);
   assign wb_we_o   = we_q;
   assign wb_sel_o  = sel_q;
   assign wb_addr_o = addr_q;
   assign wb_data_o = wdata_q;
   assign bus_err_o = err_q;

endmodule

// File: tb/tb_obi_wb_arbiter.sv
// Scoreboard bench for obi_wb_arbiter with a
// programmable-latency Wishbone slave model.
module tb_obi_wb_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_req, instr_gnt, instr_rvalid;
   logic [31:0] instr_addr, instr_rdata;
   logic        data_req, data_gnt, data_we, data_rvalid;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        wb_cyc, wb_stb, wb_we, wb_ack, bus_err;
   logic [3:0]  wb_sel;
   logic [31:0] wb_addr, wb_wdat, wb_rdat;

   typedef struct {
      bit          port;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      int          blen;
      bit          tmo;
      int          gcyc;
   } txn_t;

   txn_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc_n = 0;
   int   bus_cnt = 0;
   int   bus_len = 0;
   int   ack_at = 1;
   int   gnt_cnt = 0;
   bit   model_last = 1'b1;
   bit   err_model = 1'b0;
   bit   last_port = 1'b0;
   bit   saw_gnt = 1'b0;

   obi_wb_arbiter #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .instr_req_i    (instr_req),
      .instr_gnt_o    (instr_gnt),
      .instr_addr_i   (instr_addr),
      .instr_rvalid_o (instr_rvalid),
      .instr_rdata_o  (instr_rdata),
      .data_req_i     (data_req),
      .data_gnt_o     (data_gnt),
      .data_we_i      (data_we),
      .data_be_i      (data_be),
      .data_addr_i    (data_addr),
      .data_wdata_i   (data_wdata),
      .data_rvalid_o  (data_rvalid),
      .data_rdata_o   (data_rdata),
      .wb_cyc_o       (wb_cyc),
      .wb_stb_o       (wb_stb),
      .wb_we_o        (wb_we),
      .wb_sel_o       (wb_sel),
      .wb_addr_o      (wb_addr),
      .wb_data_o      (wb_wdat),
      .wb_data_i      (wb_rdat),
      .wb_ack_i       (wb_ack),
      .bus_err_o      (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (a == 32'h100) return 32'h13;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Slave model, grant model and response scoreboard, once per cycle.
   task automatic mon();
      txn_t e;
      bit   p;
      cyc_n++;
      saw_gnt = 1'b0;
      if (!rst_n) begin
         q.delete();
         model_last = 1'b1;
         err_model  = 1'b0;
         bus_cnt    = 0;
         wb_ack     = 1'b0;
         return;
      end
      if (wb_cyc) begin
         bus_cnt++;
         if (bus_cnt == 1 && q.size() != 0) begin
            chk("wb_stb", 32'(wb_stb), 32'(1));
            chk("wb_we", 32'(wb_we), 32'(q[0].we));
            chk("wb_sel", 32'(wb_sel), 32'(q[0].sel));
            chk("wb_addr", wb_addr, q[0].addr);
            chk("wb_wdata", wb_wdat, q[0].wdata);
         end
         if (bus_cnt == ack_at) begin
            wb_ack  = 1'b1;
            wb_rdat = rd(wb_addr);
         end else begin
            wb_ack  = 1'b0;
            wb_rdat = $urandom;
         end
      end else begin
         if (bus_cnt != 0) bus_len = bus_cnt;
         bus_cnt = 0;
         wb_ack  = 1'b0;
      end
      if (instr_gnt || data_gnt) begin
         p = (instr_req && data_req) ? !model_last : data_req;
         chk("gnt_port", 32'(data_gnt), 32'(p));
         chk("gnt_onehot", 32'(instr_gnt & data_gnt), 32'(0));
         chk("gnt_busy", 32'(q.size()), 32'(0));
         e.port = p;
         e.gcyc = cyc_n;
         e.tmo  = (ack_at == 0 || ack_at > TO);
         if (p) begin
            e.we    = data_we;
            e.sel   = data_be;
            e.addr  = data_addr;
            e.wdata = data_wdata;
         end else begin
            e.we    = 1'b0;
            e.sel   = 4'hF;
            e.addr  = instr_addr;
            e.wdata = 32'h0;
         end
         e.rdata = e.tmo ? 32'hDEADBEEF : (e.we ? 32'h0 : rd(e.addr));
         e.lat   = e.tmo ? TO + 1 : ack_at + 1;
         e.blen  = e.tmo ? TO : ack_at;
         q.push_back(e);
         model_last = p;
         last_port  = p;
         saw_gnt    = 1'b1;
         gnt_cnt++;
      end
      if (instr_rvalid || data_rvalid) begin
         if (q.size() == 0) begin
            chk("rv_spurious", 32'(1), 32'(0));
         end else begin
            e = q.pop_front();
            if (e.tmo) err_model = 1'b1;
            chk("rv_port", 32'(data_rvalid), 32'(e.port));
            chk("rv_both", 32'(instr_rvalid & data_rvalid), 32'(0));
            chk("rdata", e.port ? data_rdata : instr_rdata, e.rdata);
            chk("latency", 32'(cyc_n - e.gcyc), 32'(e.lat));
            chk("cyc_len", 32'(bus_len), 32'(e.blen));
            chk("bus_err", 32'(bus_err), 32'(err_model));
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 40) begin
         tick();
         k++;
      end
      chk("drain", 32'(q.size()), 32'(0));
      tick();
   endtask

   task automatic instr_txn(input logic [31:0] a, input int ack);
      int k = 0;
      ack_at     = ack;
      instr_addr = a;
      instr_req  = 1'b1;
      do begin
         tick();
         k++;
      end while (!saw_gnt && k < 20);
      chk("gnt_wait_i", 32'(saw_gnt), 32'(1));
      instr_req = 1'b0;
      drain();
   endtask

   task automatic data_txn(input logic [31:0] a, input logic we,
                           input logic [3:0] be, input logic [31:0] wd,
                           input int ack);
      int k = 0;
      ack_at     = ack;
      data_addr  = a;
      data_we    = we;
      data_be    = be;
      data_wdata = wd;
      data_req   = 1'b1;
      do begin
         tick();
         k++;
      end while (!saw_gnt && k < 20);
      chk("gnt_wait_d", 32'(saw_gnt), 32'(1));
      data_req = 1'b0;
      drain();
   endtask

   initial begin
      int k;
      rst_n      = 1'b0;
      instr_req  = 1'b0;
      instr_addr = '0;
      data_req   = 1'b0;
      data_we    = 1'b0;
      data_be    = '0;
      data_addr  = '0;
      data_wdata = '0;
      wb_ack     = 1'b0;
      wb_rdat    = '0;
      #3;
      chk("rst_cyc", 32'(wb_cyc | wb_stb), 32'(0));
      chk("rst_wb", {wb_we, wb_sel, wb_addr[26:0]}, 32'(0));
      chk("rst_wdat", wb_wdat, 32'(0));
      chk("rst_gnt", 32'({instr_gnt, data_gnt}), 32'(0));
      chk("rst_rv", 32'({instr_rvalid, data_rvalid}), 32'(0));
      chk("rst_rdata", instr_rdata | data_rdata, 32'(0));
      chk("rst_err", 32'(bus_err), 32'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      instr_txn(32'h100, 3);
      data_txn(32'h2000, 1'b1, 4'b0011, 32'hCAFEBABE, 2);
      data_txn(32'h2004, 1'b0, 4'hF, 32'h0, 1);
      instr_txn(32'h104, 5);
      data_txn(32'h2008, 1'b1, 4'b1100, 32'h12345678, 4);

      ack_at     = 1;
      instr_addr = 32'h400;
      data_addr  = 32'h3000;
      data_we    = 1'b0;
      data_be    = 4'hF;
      instr_req  = 1'b1;
      data_req   = 1'b1;
      gnt_cnt    = 0;
      k = 0;
      while (gnt_cnt < 6 && k < 60) begin
         tick();
         k++;
      end
      instr_req = 1'b0;
      data_req  = 1'b0;
      chk("contend_cnt", 32'(gnt_cnt), 32'(6));
      drain();

      instr_txn(32'h180, TO);
      chk("err_edge", 32'(bus_err), 32'(0));
      instr_txn(32'h1C0, 0);
      chk("err_set", 32'(bus_err), 32'(1));
      data_txn(32'h2010, 1'b0, 4'hF, 32'h0, 2);
      chk("err_sticky", 32'(bus_err), 32'(1));

      ack_at     = 0;
      data_addr  = 32'h2020;
      data_we    = 1'b1;
      data_be    = 4'hF;
      data_wdata = 32'h55;
      data_req   = 1'b1;
      k = 0;
      do begin
         tick();
         k++;
      end while (!saw_gnt && k < 20);
      chk("gnt_wait_r", 32'(saw_gnt), 32'(1));
      instr_req = 1'b1;
      tick();
      tick();
      chk("mid_cyc", 32'(wb_cyc), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cyc", 32'({wb_cyc, wb_stb}), 32'(0));
      chk("arst_gnt", 32'({instr_gnt, data_gnt}), 32'(0));
      chk("arst_rv", 32'({instr_rvalid, data_rvalid}), 32'(0));
      chk("arst_err", 32'(bus_err), 32'(0));
      tick();
      tick();
      ack_at = 2;
      rst_n  = 1'b1;
      k = 0;
      do begin
         tick();
         k++;
      end while (!saw_gnt && k < 20);
      chk("rst_tie", 32'(last_port), 32'(0));
      instr_req = 1'b0;
      data_req  = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
